// File: rtl/ring_lock_search.sv
// ring_lock_search: loads NUM_RING rings of RING_LEN values serially, finds one
// rotation pin per ring that matches the key under the selected alignment mode,
// sums the aligned slots, sorts the sums with an odd-even transposition network
// and streams the sorted sums together with the pins.
// Optional build macro RING_LOCK_DESC_EN adds a sort_dir input (1 = descending).
//
// Interface: in_valid qualifies one input beat per cycle and is only looked at in
// IDLE and LOAD; there is no in_ready, so the source must hold off while busy=1.
// out_valid qualifies one output beat per cycle with no backpressure; out_err is
// meaningful only while out_valid is high.
module ring_lock_search #(
   parameter int NUM_RING = 3,
   parameter int RING_LEN = 8,
   parameter int DW       = 5,
   localparam int OUT_W   = DW + $clog2(NUM_RING),
   localparam int PW      = $clog2(RING_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [1:0]       mode,
   input  logic [DW-1:0]    in,
   input  logic [DW-1:0]    key,
`ifdef RING_LOCK_DESC_EN
   input  logic             sort_dir,
`endif
   output logic             busy,
   output logic             out_valid,
   output logic             out_err,
   output logic [PW-1:0]    circle,
   output logic [OUT_W-1:0] value
);

   localparam int RW = (NUM_RING > 1) ? $clog2(NUM_RING) : 1;
   localparam logic [PW-1:0] LAST_SLOT = PW'(RING_LEN - 1);
   localparam logic [RW-1:0] LAST_RING = RW'(NUM_RING - 1);
   localparam logic [PW-1:0] OFS_Q1    = PW'(RING_LEN / 4);
   localparam logic [PW-1:0] OFS_Q2    = PW'(RING_LEN / 2);
   localparam logic [PW-1:0] OFS_Q3    = PW'((3 * RING_LEN) / 4);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SEARCH, S_SUM, S_SORT, S_OUTPUT, S_ERR
   } state_t;

   state_t state, next_state;

   logic [DW-1:0]    ring_mem [NUM_RING][RING_LEN];
   logic [DW-1:0]    key_q;
   logic [1:0]       mode_q;
   logic             desc_q;
   logic [RW-1:0]    ld_ring, sr;
   logic [PW-1:0]    ld_slot, si, ph, out_k;
   logic [PW-1:0]    pins [NUM_RING];
   logic [OUT_W-1:0] sums [RING_LEN];
   logic [OUT_W-1:0] sum_comb [RING_LEN];
   logic [OUT_W-1:0] sort_next [RING_LEN];
   logic             match, ld_last;
   logic [PW-1:0]    nk;
   logic [OUT_W-1:0] val_n;
   logic [PW-1:0]    circ_n;

   assign ld_last = (ld_ring == LAST_RING) && (ld_slot == LAST_SLOT);

`ifdef RING_LOCK_DESC_EN
   // Direction is captured with the key so it stays fixed for the whole transaction
   always_ff @(posedge clk) begin
      if (rst) desc_q <= 1'b0;
      else if (state == S_IDLE && in_valid) desc_q <= sort_dir;
   end
`else
   assign desc_q = 1'b0;
`endif

   // Ring storage: written on accepted beats only, never cleared
   always_ff @(posedge clk) begin
      if (in_valid && (state == S_IDLE || state == S_LOAD))
         ring_mem[ld_ring][ld_slot] <= in;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (in_valid) next_state = S_LOAD;
         S_LOAD:   if (in_valid && ld_last) next_state = S_SEARCH;
         S_SEARCH: begin
            if (match) begin
               if (sr == LAST_RING) next_state = S_SUM;
            end else if (si == LAST_SLOT) begin
               next_state = S_ERR;
            end
         end
         S_SUM:    next_state = S_SORT;
         S_SORT:   if (ph == LAST_SLOT) next_state = S_OUTPUT;
         S_OUTPUT: if (out_k == LAST_SLOT) next_state = S_IDLE;
         S_ERR:    next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Candidate test for ring sr at index si; rings after ring 0 must also agree
   // with ring 0 (rotated by its pin) at every offset of the selected mode
   always_comb begin : match_calc
      logic [PW-1:0] a1, a2, a3, b1, b2, b3;
      a1 = si + OFS_Q1;
      a2 = si + OFS_Q2;
      a3 = si + OFS_Q3;
      b1 = pins[0] + OFS_Q1;
      b2 = pins[0] + OFS_Q2;
      b3 = pins[0] + OFS_Q3;
      match = (ring_mem[sr][si] == key_q);
      if (sr != '0) begin
         if (mode_q == 2'd1) begin
            match = match && (ring_mem[sr][a2] == ring_mem[0][b2]);
         end else if (mode_q[1]) begin
            match = match && (ring_mem[sr][a1] == ring_mem[0][b1])
                          && (ring_mem[sr][a2] == ring_mem[0][b2])
                          && (ring_mem[sr][a3] == ring_mem[0][b3]);
         end
      end
   end

   // Per-slot sum of all rings, each rotated by its pin
   always_comb begin : sum_calc
      logic [OUT_W-1:0] acc;
      logic [PW-1:0]    idx;
      acc = '0;
      idx = '0;
      for (int k = 0; k < RING_LEN; k++) begin
         acc = '0;
         for (int r = 0; r < NUM_RING; r++) begin
            idx = pins[r] + PW'(k);
            acc = acc + OUT_W'(ring_mem[r][idx]);
         end
         sum_comb[k] = acc;
      end
   end

   // One odd-even transposition phase; even phases pair (0,1),(2,3)..., odd (1,2)...
   always_comb begin : sort_calc
      logic [OUT_W-1:0] tmp;
      logic             swap;
      tmp  = '0;
      swap = 1'b0;
      for (int k = 0; k < RING_LEN; k++) sort_next[k] = sums[k];
      for (int j = 0; j < RING_LEN - 1; j++) begin
         if (j[0] == ph[0]) begin
            swap = desc_q ? (sort_next[j] < sort_next[j+1])
                          : (sort_next[j] > sort_next[j+1]);
            if (swap) begin
               tmp            = sort_next[j];
               sort_next[j]   = sort_next[j+1];
               sort_next[j+1] = tmp;
            end
         end
      end
   end

   // Datapath registers: load counters, search cursor, pins, sums, sort/output counters
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_ring <= '0;
         ld_slot <= '0;
         sr      <= '0;
         si      <= '0;
         ph      <= '0;
         out_k   <= '0;
         key_q   <= '0;
         mode_q  <= '0;
         for (int r = 0; r < NUM_RING; r++) pins[r] <= '0;
         for (int k = 0; k < RING_LEN; k++) sums[k] <= '0;
      end else begin
         case (state)
            S_IDLE, S_LOAD: begin
               if (state == S_IDLE) begin
                  sr <= '0;
                  si <= '0;
               end
               if (in_valid) begin
                  if (state == S_IDLE) begin
                     key_q  <= key;
                     mode_q <= mode;
                  end
                  if (ld_slot == LAST_SLOT) begin
                     ld_slot <= '0;
                     ld_ring <= ld_last ? '0 : ld_ring + RW'(1);
                  end else begin
                     ld_slot <= ld_slot + PW'(1);
                  end
               end
            end
            S_SEARCH: begin
               if (match) begin
                  pins[sr] <= si;
                  si       <= '0;
                  sr       <= (sr == LAST_RING) ? '0 : sr + RW'(1);
               end else begin
                  si <= si + PW'(1);
               end
            end
            S_SUM: begin
               for (int k = 0; k < RING_LEN; k++) sums[k] <= sum_comb[k];
               ph <= '0;
            end
            S_SORT: begin
               for (int k = 0; k < RING_LEN; k++) sums[k] <= sort_next[k];
               ph    <= ph + PW'(1);
               out_k <= '0;
            end
            S_OUTPUT: out_k <= out_k + PW'(1);
            default: ;
         endcase
      end
   end

   // Beat about to be presented: index, sorted value and pin for that index
   always_comb begin
      nk     = (state == S_OUTPUT) ? out_k + PW'(1) : '0;
      val_n  = (state == S_SORT) ? sort_next[nk] : sums[nk];
      circ_n = '0;
      for (int r = 0; r < NUM_RING; r++)
         if (r == int'(nk)) circ_n = pins[r];
   end

   // Registered outputs, computed from the next state so they line up with it
   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_err   <= 1'b0;
         circle    <= '0;
         value     <= '0;
      end else begin
         busy      <= (next_state != S_IDLE);
         out_valid <= 1'b0;
         out_err   <= 1'b0;
         circle    <= '0;
         value     <= '0;
         if (next_state == S_OUTPUT) begin
            out_valid <= 1'b1;
            value     <= val_n;
            circle    <= circ_n;
         end else if (next_state == S_ERR) begin
            out_valid <= 1'b1;
            out_err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ring_lock_search.sv
// Bench for ring_lock_search: directed cases plus randomized transactions checked
// against a brute-force pin search, arithmetic sums and an insertion-sort model.
module tb_ring_lock_search;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] mode;
   logic [7:0] din, key;
   logic       iv_s, iv_b;

   logic       busy_s, ov_s, oe_s;
   logic [2:0] circ_s;
   logic [6:0] val_s;
   logic       busy_b, ov_b, oe_b;
   logic [3:0] circ_b;
   logic [9:0] val_b;

   ring_lock_search dut (
      .clk(clk), .rst(rst), .in_valid(iv_s), .mode(mode),
      .in(din[4:0]), .key(key[4:0]),
`ifdef RING_LOCK_DESC_EN
      .sort_dir(1'b0),
`endif
      .busy(busy_s), .out_valid(ov_s), .out_err(oe_s),
      .circle(circ_s), .value(val_s)
   );

   ring_lock_search #(.NUM_RING(4), .RING_LEN(16), .DW(8)) dut_big (
      .clk(clk), .rst(rst), .in_valid(iv_b), .mode(mode),
      .in(din), .key(key),
`ifdef RING_LOCK_DESC_EN
      .sort_dir(1'b0),
`endif
      .busy(busy_b), .out_valid(ov_b), .out_err(oe_b),
      .circle(circ_b), .value(val_b)
   );

   bit          use_big;
   logic        t_ov, t_oe, t_busy;
   logic [15:0] t_val, t_circ;
   assign t_ov   = use_big ? ov_b : ov_s;
   assign t_oe   = use_big ? oe_b : oe_s;
   assign t_busy = use_big ? busy_b : busy_s;
   assign t_val  = use_big ? 16'(val_b) : 16'(val_s);
   assign t_circ = use_big ? 16'(circ_b) : 16'(circ_s);

   int n_checks, n_fail;

   // stimulus and reference model state
   int          m_nr, m_len, m_key, m_mode;
   int          m_ring [8][16];
   bit          m_err;
   int          m_pins [8];
   logic [15:0] exp_q [$];
   int          gap_at, gap_len;
   bit          rand_gaps;

   // captured output stream
   int          got_n, lat;
   logic        got_busy_after;
   logic        got_err [32];
   logic [15:0] got_val [32], got_circ [32];

   // Reference: brute-force pin search, per-slot sums, ascending insertion sort
   task automatic model_run();
      int offs [$];
      int sums [16];
      int v, j;
      bit ok, found;
      exp_q.delete();
      offs.delete();
      m_err = 1'b0;
      if (m_mode == 1) offs.push_back(m_len / 2);
      else if (m_mode >= 2) begin
         offs.push_back(m_len / 4);
         offs.push_back(m_len / 2);
         offs.push_back(3 * m_len / 4);
      end
      for (int r = 0; r < m_nr; r++) begin
         found = 1'b0;
         for (int i = 0; i < m_len; i++) begin
            if (!found) begin
               ok = (m_ring[r][i] == m_key);
               if (r > 0)
                  foreach (offs[q])
                     if (m_ring[r][(i + offs[q]) % m_len] != m_ring[0][(m_pins[0] + offs[q]) % m_len])
                        ok = 1'b0;
               if (ok) begin
                  m_pins[r] = i;
                  found = 1'b1;
               end
            end
         end
         if (!found) begin
            m_err = 1'b1;
            break;
         end
      end
      if (m_err) begin
         exp_q.push_back(16'd0);
         return;
      end
      for (int k = 0; k < m_len; k++) begin
         sums[k] = 0;
         for (int r = 0; r < m_nr; r++) sums[k] += m_ring[r][(m_pins[r] + k) % m_len];
      end
      for (int i = 1; i < m_len; i++) begin
         v = sums[i];
         j = i - 1;
         while (j >= 0 && sums[j] > v) begin
            sums[j+1] = sums[j];
            j--;
         end
         sums[j+1] = v;
      end
      for (int k = 0; k < m_len; k++) exp_q.push_back(16'(sums[k]));
   endtask

   // Drive one transaction from m_ring; key/mode are scrambled after beat 0
   task automatic drive_txn();
      int g;
      for (int b = 0; b < m_nr * m_len; b++) begin
         g = 0;
         if (b == gap_at) g = gap_len;
         else if (rand_gaps && b > 0 && $urandom_range(0, 3) == 0) g = $urandom_range(1, 2);
         repeat (g) begin
            iv_s = 1'b0;
            iv_b = 1'b0;
            din  = 8'($urandom);
            key  = 8'($urandom);
            mode = 2'($urandom);
            @(posedge clk);
            #1;
         end
         din = 8'(m_ring[b / m_len][b % m_len]);
         if (b == 0) begin
            key  = 8'(m_key);
            mode = 2'(m_mode);
         end else begin
            key  = 8'($urandom);
            mode = 2'($urandom);
         end
         if (use_big) iv_b = 1'b1;
         else         iv_s = 1'b1;
         @(posedge clk);
         #1;
      end
      iv_s = 1'b0;
      iv_b = 1'b0;
   endtask

   // Capture the output burst (bounded wait), and busy on the cycle after it
   task automatic collect();
      int cyc;
      cyc = 0;
      got_n = 0;
      lat = 0;
      got_busy_after = 1'bx;
      for (int k = 0; k < 32; k++) begin
         got_val[k]  = 'x;
         got_circ[k] = 'x;
         got_err[k]  = 1'bx;
      end
      do begin
         @(negedge clk);
         cyc++;
      end while (t_ov !== 1'b1 && cyc < 1000);
      if (t_ov === 1'b1) begin
         lat = cyc;
         while (t_ov === 1'b1 && got_n < 32) begin
            got_val[got_n]  = t_val;
            got_circ[got_n] = t_circ;
            got_err[got_n]  = t_oe;
            got_n++;
            @(negedge clk);
         end
         got_busy_after = t_busy;
      end
   endtask

   task automatic load_basic();
      m_nr = 3;
      m_len = 8;
      for (int r = 0; r < 8; r++)
         for (int i = 0; i < 16; i++)
            m_ring[r][i] = (r == 0 && i < 8) ? i + 1 : 0;
      m_ring[1][2] = 5;
      m_ring[2][7] = 5;
      m_key = 5;
      m_mode = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (busy_s !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %0b exp 0", busy_s); end
      n_checks++; if (ov_s !== 1'b0)     begin n_fail++; $display("FAIL reset_out_valid got %0b exp 0", ov_s); end
      n_checks++; if (oe_s !== 1'b0)     begin n_fail++; $display("FAIL reset_out_err got %0b exp 0", oe_s); end
      n_checks++; if (circ_s !== 3'd0)   begin n_fail++; $display("FAIL reset_circle got %0d exp 0", circ_s); end
      n_checks++; if (val_s !== 7'd0)    begin n_fail++; $display("FAIL reset_value got %0d exp 0", val_s); end
      n_checks++; if (busy_b !== 1'b0)   begin n_fail++; $display("FAIL reset_big_busy got %0b exp 0", busy_b); end
      n_checks++; if (ov_b !== 1'b0)     begin n_fail++; $display("FAIL reset_big_out_valid got %0b exp 0", ov_b); end
   endtask

   // First directed case; gap > 0 stalls in_valid before beat 'gap'
   task automatic test_basic(input string tag, input int gap);
      int e_val [8] = '{1, 2, 3, 4, 6, 7, 8, 15};
      int e_pin [3] = '{4, 2, 7};
      logic [15:0] ec;
      use_big = 1'b0;
      load_basic();
      gap_at = gap;
      gap_len = 3;
      rand_gaps = 1'b0;
      drive_txn();
      collect();
      n_checks++; if (got_n != 8) begin n_fail++; $display("FAIL %s_count got %0d exp 8", tag, got_n); end
      for (int k = 0; k < 8; k++) begin
         ec = (k < 3) ? 16'(e_pin[k]) : 16'd0;
         n_checks++; if (got_val[k] !== 16'(e_val[k])) begin n_fail++; $display("FAIL %s_value[%0d] got %0d exp %0d", tag, k, got_val[k], e_val[k]); end
         n_checks++; if (got_circ[k] !== ec) begin n_fail++; $display("FAIL %s_circle[%0d] got %0d exp %0d", tag, k, got_circ[k], ec); end
         n_checks++; if (got_err[k] !== 1'b0) begin n_fail++; $display("FAIL %s_err[%0d] got %0b exp 0", tag, k, got_err[k]); end
      end
      n_checks++; if (got_busy_after !== 1'b0) begin n_fail++; $display("FAIL %s_busy_after got %0b exp 0", tag, got_busy_after); end
   endtask

   task automatic test_mode1();
      int e_val [8] = '{2, 3, 3, 4, 7, 8, 11, 15};
      int e_pin [3] = '{4, 7, 7};
      logic [15:0] ec;
      use_big = 1'b0;
      load_basic();
      m_ring[1][2] = 0;
      m_ring[1][0] = 5;
      m_ring[1][7] = 5;
      m_ring[1][3] = 1;
      m_ring[1][4] = 0;
      m_ring[2][3] = 1;
      m_mode = 1;
      gap_at = -1;
      rand_gaps = 1'b0;
      drive_txn();
      collect();
      n_checks++; if (got_n != 8) begin n_fail++; $display("FAIL mode1_count got %0d exp 8", got_n); end
      for (int k = 0; k < 8; k++) begin
         ec = (k < 3) ? 16'(e_pin[k]) : 16'd0;
         n_checks++; if (got_val[k] !== 16'(e_val[k])) begin n_fail++; $display("FAIL mode1_value[%0d] got %0d exp %0d", k, got_val[k], e_val[k]); end
         n_checks++; if (got_circ[k] !== ec) begin n_fail++; $display("FAIL mode1_circle[%0d] got %0d exp %0d", k, got_circ[k], ec); end
      end
   endtask

   task automatic test_not_found();
      use_big = 1'b0;
      load_basic();
      m_key = 31;
      gap_at = -1;
      rand_gaps = 1'b0;
      drive_txn();
      collect();
      n_checks++; if (got_n != 1) begin n_fail++; $display("FAIL nf_count got %0d exp 1", got_n); end
      n_checks++; if (got_err[0] !== 1'b1) begin n_fail++; $display("FAIL nf_err got %0b exp 1", got_err[0]); end
      n_checks++; if (got_val[0] !== 16'd0) begin n_fail++; $display("FAIL nf_value got %0d exp 0", got_val[0]); end
      n_checks++; if (got_circ[0] !== 16'd0) begin n_fail++; $display("FAIL nf_circle got %0d exp 0", got_circ[0]); end
      // 8 SEARCH cycles after the last beat, error beat on the 9th cycle
      n_checks++; if (lat != 9) begin n_fail++; $display("FAIL nf_latency got %0d exp 9", lat); end
      n_checks++; if (got_busy_after !== 1'b0) begin n_fail++; $display("FAIL nf_busy_after got %0b exp 0", got_busy_after); end
   endtask

   task automatic test_reset_mid();
      use_big = 1'b0;
      load_basic();
      gap_at = -1;
      rand_gaps = 1'b0;
      drive_txn();
      // 16 SEARCH + 1 SUM cycles, so 20 cycles later the block is mid-SORT
      repeat (20) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %0b exp 0", busy_s); end
      n_checks++; if (ov_s !== 1'b0)   begin n_fail++; $display("FAIL midrst_out_valid got %0b exp 0", ov_s); end
      n_checks++; if (oe_s !== 1'b0)   begin n_fail++; $display("FAIL midrst_out_err got %0b exp 0", oe_s); end
      n_checks++; if (circ_s !== 3'd0) begin n_fail++; $display("FAIL midrst_circle got %0d exp 0", circ_s); end
      n_checks++; if (val_s !== 7'd0)  begin n_fail++; $display("FAIL midrst_value got %0d exp 0", val_s); end
      test_basic("after_rst", -1);
   endtask

   task automatic test_random();
      int hi, exp_n;
      logic [15:0] ev, ec;
      use_big = 1'b0;
      m_nr = 3;
      m_len = 8;
      gap_at = -1;
      rand_gaps = 1'b1;
      for (int it = 0; it < 40; it++) begin
         hi = (it % 4 == 3) ? 31 : 3;
         for (int r = 0; r < 3; r++)
            for (int i = 0; i < 8; i++) m_ring[r][i] = $urandom_range(0, hi);
         m_key = (hi == 3) ? $urandom_range(0, 3) : m_ring[0][$urandom_range(0, 7)];
         m_mode = $urandom_range(0, 3);
         model_run();
         drive_txn();
         collect();
         exp_n = m_err ? 1 : 8;
         n_checks++; if (got_n != exp_n) begin n_fail++; $display("FAIL rand%0d_count got %0d exp %0d", it, got_n, exp_n); end
         for (int k = 0; k < exp_n && k < got_n; k++) begin
            ev = exp_q.pop_front();
            ec = (m_err || k >= 3) ? 16'd0 : 16'(m_pins[k]);
            n_checks++; if (got_val[k] !== ev) begin n_fail++; $display("FAIL rand%0d_value[%0d] got %0d exp %0d", it, k, got_val[k], ev); end
            n_checks++; if (got_circ[k] !== ec) begin n_fail++; $display("FAIL rand%0d_circle[%0d] got %0d exp %0d", it, k, got_circ[k], ec); end
            n_checks++; if (got_err[k] !== m_err) begin n_fail++; $display("FAIL rand%0d_err[%0d] got %0b exp %0b", it, k, got_err[k], m_err); end
         end
         n_checks++; if (got_busy_after !== 1'b0) begin n_fail++; $display("FAIL rand%0d_busy_after got %0b exp 0", it, got_busy_after); end
      end
   endtask

   // 4 rings of 16 slots, 8-bit data: all-255 case first, then random rings
   task automatic test_big();
      int exp_n;
      logic [15:0] ev, ec;
      use_big = 1'b1;
      m_nr = 4;
      m_len = 16;
      gap_at = -1;
      for (int it = 0; it < 5; it++) begin
         rand_gaps = (it > 0);
         for (int r = 0; r < 4; r++)
            for (int i = 0; i < 16; i++) m_ring[r][i] = (it == 0) ? 255 : $urandom_range(0, 3);
         m_key = (it == 0) ? 255 : $urandom_range(0, 3);
         m_mode = (it == 0) ? 2 : $urandom_range(0, 3);
         model_run();
         drive_txn();
         collect();
         exp_n = m_err ? 1 : 16;
         n_checks++; if (got_n != exp_n) begin n_fail++; $display("FAIL big%0d_count got %0d exp %0d", it, got_n, exp_n); end
         for (int k = 0; k < exp_n && k < got_n; k++) begin
            ev = exp_q.pop_front();
            ec = (m_err || k >= 4) ? 16'd0 : 16'(m_pins[k]);
            n_checks++; if (got_val[k] !== ev) begin n_fail++; $display("FAIL big%0d_value[%0d] got %0d exp %0d", it, k, got_val[k], ev); end
            n_checks++; if (got_circ[k] !== ec) begin n_fail++; $display("FAIL big%0d_circle[%0d] got %0d exp %0d", it, k, got_circ[k], ec); end
            n_checks++; if (got_err[k] !== m_err) begin n_fail++; $display("FAIL big%0d_err[%0d] got %0b exp %0b", it, k, got_err[k], m_err); end
         end
      end
      use_big = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst = 1'b1;
      iv_s = 1'b0;
      iv_b = 1'b0;
      din = '0;
      key = '0;
      mode = '0;
      use_big = 1'b0;
      test_reset();
      test_basic("basic", -1);
      test_mode1();
      test_not_found();
      test_basic("gap", 11);
      test_reset_mid();
      test_random();
      test_big();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
